// File: rtl/rv32_rf_write_arbiter.sv
// rv32_rf_write_arbiter
// Owns the single register-file write port and shares it between the in-order
// writeback stage and a long-latency unit. Long-unit results wait in a small FIFO.
// The FIFO head competes with pipeline writes for the port. Its wait is bounded
// by MAX_WAIT. A pending-destination mask is exported for the hazard unit.
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   pipe_reg_write/pipe_rd/pipe_wb_data  WB stage write request
//   pipe_stall                        WB write denied this cycle
//   lu_valid/lu_rd/lu_data, lu_ready  long-unit result handshake
//   rf_we/rf_rd/rf_wdata              register-file write port
//   pend_mask                         destinations still buffered in the FIFO
//   fifo_count                        number of buffered results
module rv32_rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     pipe_reg_write,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_wb_data,
  output logic                     pipe_stall,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_rd,
  input  logic [31:0]              lu_data,
  output logic                     rf_we,
  output logic [4:0]               rf_rd,
  output logic [31:0]              rf_wdata,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wait;

  logic          w_pipeReq;
  logic          w_headReq;
  logic          w_full;
  logic          w_grantHead;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_pendMask;

  // Buffered destinations. Only the entries counted from the read pointer are
  // live, so stale slots never leak into the mask.
  always_comb begin
    w_pendMask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < r_count) begin
        w_pendMask[r_rd[r_rptr + AW'(k)]] = 1'b1;
      end
    end
    w_pendMask[0] = 1'b0;
  end

  assign w_pipeReq = pipe_reg_write & (pipe_rd != 5'd0);
  assign w_headReq = (r_count != '0);
  assign w_full    = (r_count == FULL_CNT);

  // The head wins if the pipe is idle or the head has starved long enough.
  // It also wins if the FIFO is full, or if the pipe targets a register with
  // an older buffered write. The last case keeps the final value the
  // program-order one.
  assign w_grantHead = w_headReq & (~w_pipeReq | (r_wait == WAIT_MAX) | w_full |
                                    w_pendMask[pipe_rd]);

  // Writes to x0 complete the handshake but are never stored.
  assign w_push = lu_valid & ~w_full & (lu_rd != 5'd0);
  assign w_pop  = w_grantHead;

  always_comb begin
    rf_we    = w_pipeReq | w_headReq;
    rf_rd    = 5'd0;
    rf_wdata = 32'd0;
    if (w_grantHead) begin
      rf_rd    = r_rd[r_rptr];
      rf_wdata = r_data[r_rptr];
    end else if (w_pipeReq) begin
      rf_rd    = pipe_rd;
      rf_wdata = pipe_wb_data;
    end
  end

  assign pipe_stall = w_pipeReq & w_grantHead;
  assign lu_ready   = ~w_full;
  assign pend_mask  = w_pendMask;
  assign fifo_count = r_count;

  // Entry storage needs no reset; validity comes entirely from r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= lu_rd;
      r_data[r_wptr] <= lu_data;
    end
  end

  // Pointers, occupancy and the head starvation counter. The counter restarts
  // whenever the head drains or the FIFO is empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wait  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (!w_headReq || w_grantHead) r_wait <= '0;
      else if (r_wait != WAIT_MAX)   r_wait <= r_wait + WW'(1);
    end
  end

endmodule

// File: tb/tb_rv32_rf_write_arbiter.sv
// tb_rv32_rf_write_arbiter
// Drives directed scenarios and then random traffic into rv32_rf_write_arbiter.
// Each cycle's outputs are checked against a queue-based reference model of the
// arbitration rules.
module tb_rv32_rf_write_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        resetn;
  logic        pipe_reg_write;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic [1:0]  fifo_count;

  rv32_rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_reg_write(pipe_reg_write), .pipe_rd(pipe_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      modelQ[$];
  int          modelWait;
  int          checkCount;
  int          errorCount;
  logic        lastStall;
  logic [4:0]  lastRd;
  logic [31:0] lastData;
  logic [31:0] lastMask;
  logic        lastReady;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and compare the outputs with
  // the model. Advance the model on the rising edge.
  task automatic applyStimulus(input logic prw, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic luv, input logic [4:0] lrd, input logic [31:0] ldata);
    logic        expP, expH, expFull, expGrant;
    logic [4:0]  expRd;
    logic [31:0] expData, expMask;
    @(negedge clk);
    pipe_reg_write = prw;
    pipe_rd        = prd;
    pipe_wb_data   = pdata;
    lu_valid       = luv;
    lu_rd          = lrd;
    lu_data        = ldata;
    #1;
    expMask = 32'd0;
    foreach (modelQ[i]) expMask[modelQ[i].rd] = 1'b1;
    expP     = prw && (prd != 5'd0);
    expH     = (modelQ.size() != 0);
    expFull  = (modelQ.size() == DEPTH);
    expGrant = expH && (!expP || modelWait == MAX_WAIT || expFull || expMask[prd]);
    expRd    = 5'd0;
    expData  = 32'd0;
    if (expGrant) begin
      expRd   = modelQ[0].rd;
      expData = modelQ[0].data;
    end else if (expP) begin
      expRd   = prd;
      expData = pdata;
    end
    checkOutput("rf_we",      {31'd0, rf_we},      {31'd0, expP || expH});
    checkOutput("rf_rd",      {27'd0, rf_rd},      {27'd0, expRd});
    checkOutput("rf_wdata",   rf_wdata,            expData);
    checkOutput("pipe_stall", {31'd0, pipe_stall}, {31'd0, expP && expGrant});
    checkOutput("lu_ready",   {31'd0, lu_ready},   {31'd0, !expFull});
    checkOutput("fifo_count", {30'd0, fifo_count}, modelQ.size());
    checkOutput("pend_mask",  pend_mask,           expMask);
    lastStall = pipe_stall;
    lastRd    = rf_rd;
    lastData  = rf_wdata;
    lastMask  = pend_mask;
    lastReady = lu_ready;
    @(posedge clk);
    if (expGrant) void'(modelQ.pop_front());
    if (luv && !expFull && lrd != 5'd0) modelQ.push_back('{rd: lrd, data: ldata});
    if (!expH || expGrant) modelWait = 0;
    else if (modelWait < MAX_WAIT) modelWait++;
  endtask

  // Assert reset mid-cycle and confirm the outputs clear immediately.
  task automatic doReset();
    @(negedge clk);
    pipe_reg_write = 1'b0;
    lu_valid       = 1'b0;
    resetn         = 1'b0;
    #1;
    checkOutput("rst_count", {30'd0, fifo_count}, 32'd0);
    checkOutput("rst_mask",  pend_mask,           32'd0);
    checkOutput("rst_we",    {31'd0, rf_we},      32'd0);
    checkOutput("rst_stall", {31'd0, pipe_stall}, 32'd0);
    checkOutput("rst_ready", {31'd0, lu_ready},   32'd1);
    modelQ.delete();
    modelWait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic        prw;
    logic [4:0]  prd;
    logic [31:0] pdata;
    checkCount     = 0;
    errorCount     = 0;
    modelWait      = 0;
    lastStall      = 1'b0;
    resetn         = 1'b1;
    pipe_reg_write = 1'b0;
    pipe_rd        = 5'd0;
    pipe_wb_data   = 32'd0;
    lu_valid       = 1'b0;
    lu_rd          = 5'd0;
    lu_data        = 32'd0;
    doReset();

    $display("[TB] pipe write with empty FIFO");
    applyStimulus(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'd0);
    checkOutput("t1_rd",    {27'd0, lastRd}, 32'd5);
    checkOutput("t1_data",  lastData,        32'hA5);
    checkOutput("t1_stall", {31'd0, lastStall}, 32'd0);

    $display("[TB] long-unit result drains next cycle");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t2_rd",   {27'd0, lastRd}, 32'd7);
    checkOutput("t2_data", lastData,        32'h11);
    checkOutput("t2_pend", {31'd0, lastMask[7]}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t2_pend_clr", {31'd0, lastMask[7]}, 32'd0);

    $display("[TB] bounded wait of the FIFO head");
    applyStimulus(1'b1, 5'd4, 32'h400, 1'b1, 5'd3, 32'h33);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 5'd4, 32'h401 + k, 1'b0, 5'd0, 32'd0);
      checkOutput("t3_stall", {31'd0, lastStall}, (k == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("t3_head_rd", {27'd0, lastRd}, 32'd3);
    applyStimulus(1'b1, 5'd4, 32'h405, 1'b0, 5'd0, 32'd0);
    checkOutput("t3_after", {31'd0, lastStall}, 32'd0);

    $display("[TB] same-destination ordering");
    applyStimulus(1'b1, 5'd2, 32'h200, 1'b1, 5'd9, 32'h99);
    applyStimulus(1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 32'd0);
    checkOutput("t4_stall",   {31'd0, lastStall}, 32'd1);
    checkOutput("t4_head",    lastData,           32'h99);
    applyStimulus(1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 32'd0);
    checkOutput("t4_pipe",    lastData,           32'h900);

    $display("[TB] fill and drain");
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hA0);
    applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd11, 32'hB0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0);
    checkOutput("t5_full_ready", {31'd0, lastReady}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hD0);
    checkOutput("t5_ready_back", {31'd0, lastReady}, 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t5_empty", {30'd0, fifo_count}, 32'd0);

    $display("[TB] reset with results buffered");
    applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd13, 32'hE0);
    applyStimulus(1'b1, 5'd1, 32'h101, 1'b1, 5'd14, 32'hF0);
    doReset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t6_no_stale", {31'd0, rf_we}, 32'd0);

    $display("[TB] random traffic");
    prw   = 1'b0;
    prd   = 5'd0;
    pdata = 32'd0;
    for (int n = 0; n < 400; n++) begin
      // A stalled WB stage keeps its request stable until it is accepted.
      if (!lastStall) begin
        prw   = ($urandom_range(0, 99) < 60);
        prd   = 5'($urandom_range(0, 7));
        pdata = $urandom;
      end
      applyStimulus(prw, prd, pdata, ($urandom_range(0, 99) < 45),
                    5'($urandom_range(0, 7)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
